vga_sync_gen: RTL and testbench
===============================

// Module: vga_sync_gen
// PURPOSE
//  Raster timing generator: the producer side of the colour path. Drives h_sync, v_sync and
//  video_on to vga_color, plus pixel coordinates for the pixel source.
//  Counts pixels and lines on a pixel-enable tick and emits line/frame strobes.
//  Default timing is 640x480@60 on a 25 MHz pixel tick.
// PARAMETERS
//  H_VISIBLE        640  visible pixels per line
//  H_FRONT          16   horizontal front porch (pixels)
//  H_SYNC           96   horizontal sync width (pixels)
//  H_BACK           48   horizontal back porch (pixels)
//  V_VISIBLE        480  visible lines per frame
//  V_FRONT          10   vertical front porch (lines)
//  V_SYNC           2    vertical sync width (lines)
//  V_BACK           33   vertical back porch (lines)
//  SYNC_ACTIVE_LOW  1    1: sync pulses drive 0, idle 1; 0: inverted
// PORTS
//  clk          in   1   system clock, one clock domain
//  rst          in   1   asynchronous, active-high reset
//  pix_en       in   1   pixel tick; counters advance only on cycles where pix_en=1
//  h_sync       out  1   horizontal sync, polarity per SYNC_ACTIVE_LOW
//  v_sync       out  1   vertical sync, polarity per SYNC_ACTIVE_LOW
//  video_on     out  1   1 when inside the visible area
//  pix_x        out  10  current horizontal count, 0..H_TOTAL-1
//  pix_y        out  10  current vertical count, 0..V_TOTAL-1
//  line_start   out  1   one-clk pulse when pix_x becomes 0
//  frame_start  out  1   one-clk pulse when (pix_x,pix_y) becomes (0,0)
//  frame_cnt    out  8   frame counter; present only with VGA_FRAME_CNT_EN
// BEHAVIOUR
//  - H_TOTAL = sum of the H_* parameters (800). V_TOTAL = sum of the V_* parameters (525).
//    Both must be <= 1024; sizes outside that are unsupported.
//  - Every output is a flop. Outputs are updated on the same edge as the counters, computed
//    from the next count. pix_x/pix_y, syncs and video_on are therefore mutually aligned
//    with zero skew.
//  - Horizontal phases (FSM, per line): VISIBLE[0..639] -> FRONT[640..655] -> SYNC[656..751]
//    -> BACK[752..799] -> VISIBLE.
//    Vertical phases (per line step): VISIBLE[0..479] -> FRONT[480..489] -> SYNC[490..491]
//    -> BACK[492..524] -> VISIBLE.
//  - On a pix_en cycle, h advances by 1. At h = H_TOTAL-1, h wraps to 0 and v advances by 1.
//    At v = V_TOTAL-1 with that h wrap, v wraps to 0.
//  - h_sync is active iff h is in the SYNC phase; v_sync is active iff v is in the SYNC phase.
//    video_on = (h < H_VISIBLE) && (v < V_VISIBLE).
//  - line_start/frame_start assert for exactly one clk, on the edge where the new count has
//    h=0 (and v=0 for frame_start). They clear on the next clk even if pix_en stays low.
//  - pix_en=0: counters, syncs, video_on and pix_x/pix_y hold. Only the strobes clear.
//  - Reset (async assert): h=H_TOTAL-1, v=V_TOTAL-1, pix_x=0, pix_y=0, syncs at the
//    inactive level, video_on=0, strobes=0, frame_cnt=0.
//    The first pix_en after release produces (0,0) with line_start=frame_start=1 and
//    video_on=1.
//  - Reset asserted mid-frame aborts immediately. No partial line or sync pulse is completed.
// CONFIGURATION
//  VGA_FRAME_CNT_EN defined: frame_cnt port exists. It increments by 1 (mod 256) on each
//    frame_start edge, including the first one after reset, so it reads 1 during the first
//    frame.
//  VGA_FRAME_CNT_EN undefined: frame_cnt port and its logic are absent. All other behaviour
//    is identical.
// TESTING
//  1. Reset, then pix_en held at 1: line_start pulses every 800 clk; frame_start every 420000
//     clk; first frame_start is on the first clk after release.
//  2. Hold pix_en=1: h_sync=0 for exactly h=656..751 (96 clk), otherwise 1.
//     v_sync=0 for exactly lines 490..491 (1600 clk).
//  3. video_on=1 only for h<640 and v<480. Check 640*480 = 307200 active clk per frame and
//     that edges are aligned with pix_x transitions.
//  4. pix_en toggling 1/0 (50 MHz clk, 25 MHz tick): pix_x advances every 2nd clk; all outputs
//     hold on pix_en=0 cycles; strobes are exactly 1 clk wide.
//  5. rst pulsed at h=700 (inside h_sync): outputs go to reset values asynchronously
//     (h_sync=1, video_on=0). After release, the first pix_en gives pix_x=0, pix_y=0,
//     frame_start=1.
//  6. With VGA_FRAME_CNT_EN: frame_cnt=1 in frame 1, then 255 -> 0 wrap after 256 frames.
//     Build without the macro and rerun 1-5 unchanged.

Source files
------------

// File: rtl/vga_sync_gen_if.sv
// Raster timing bundle between the sync generator (master) and its consumers
// (slave: colour path / pixel source). The generator samples pix_en and drives
// everything else. frame_cnt exists only when VGA_FRAME_CNT_EN is defined.
// dbg_h_phase / dbg_v_phase expose the horizontal and vertical phase FSMs
// (0 visible, 1 front porch, 2 sync, 3 back porch).
//
// Handshake: there is no valid/ready pair on this bundle. pix_en is a
// qualifier: every registered output advances only on a clk edge where
// pix_en=1, and line_start/frame_start are single-clk pulses on that edge.
interface vga_sync_gen_if;
    logic       pix_en;
    logic       h_sync;
    logic       v_sync;
    logic       video_on;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       line_start;
    logic       frame_start;
    logic [1:0] dbg_h_phase;
    logic [1:0] dbg_v_phase;
`ifdef VGA_FRAME_CNT_EN
    logic [7:0] frame_cnt;
`endif

    modport master (
        input  pix_en,
        output h_sync,
        output v_sync,
        output video_on,
        output pix_x,
        output pix_y,
        output line_start,
        output frame_start,
        output dbg_h_phase,
        output dbg_v_phase
`ifdef VGA_FRAME_CNT_EN
        , output frame_cnt
`endif
    );

    modport slave (
        output pix_en,
        input  h_sync,
        input  v_sync,
        input  video_on,
        input  pix_x,
        input  pix_y,
        input  line_start,
        input  frame_start,
        input  dbg_h_phase,
        input  dbg_v_phase
`ifdef VGA_FRAME_CNT_EN
        , input frame_cnt
`endif
    );
endinterface

// File: rtl/vga_sync_gen.sv
// Raster timing generator. Counts pixels/lines on the pix_en tick, tracks the
// horizontal and vertical phases as two small FSMs, and registers every output
// from the next-state values so coordinates, syncs and video_on share the
// same edge. Optional frame counter: define VGA_FRAME_CNT_EN.
module vga_sync_gen #(
    parameter int H_VISIBLE       = 640,
    parameter int H_FRONT         = 16,
    parameter int H_SYNC          = 96,
    parameter int H_BACK          = 48,
    parameter int V_VISIBLE       = 480,
    parameter int V_FRONT         = 10,
    parameter int V_SYNC          = 2,
    parameter int V_BACK          = 33,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic          clk,
    input  logic          rst,
    vga_sync_gen_if.master vga
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST        = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_FRONT_START = 10'(H_VISIBLE);
    localparam logic [9:0] H_SYNC_START  = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_BACK_START  = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] V_LAST        = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_FRONT_START = 10'(V_VISIBLE);
    localparam logic [9:0] V_SYNC_START  = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_BACK_START  = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    localparam logic SYNC_ON  = (SYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
    localparam logic SYNC_OFF = (SYNC_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        PH_VISIBLE = 2'd0,
        PH_FRONT   = 2'd1,
        PH_SYNC    = 2'd2,
        PH_BACK    = 2'd3
    } phase_e;

    // Phase step for a counter that just moved by one; a phase is left when
    // the new count reaches the first index of the following phase.
    function automatic phase_e step_phase(
        input phase_e     cur,
        input logic [9:0] cnt_d,
        input logic [9:0] front_start,
        input logic [9:0] sync_start,
        input logic [9:0] back_start
    );
        phase_e nxt;
        nxt = cur;
        case (cur)
            PH_VISIBLE: if (cnt_d == front_start) nxt = PH_FRONT;
            PH_FRONT:   if (cnt_d == sync_start)  nxt = PH_SYNC;
            PH_SYNC:    if (cnt_d == back_start)  nxt = PH_BACK;
            PH_BACK:    if (cnt_d == 10'd0)       nxt = PH_VISIBLE;
            default:    nxt = PH_VISIBLE;
        endcase
        return nxt;
    endfunction

    logic [9:0] h_q, h_d;
    logic [9:0] v_q, v_d;
    phase_e     h_ph_q, h_ph_d;
    phase_e     v_ph_q, v_ph_d;
    logic       h_wrap;

    logic [9:0] pix_x_q;
    logic [9:0] pix_y_q;
    logic       h_sync_q;
    logic       v_sync_q;
    logic       video_on_q;
    logic       line_start_q;
    logic       frame_start_q;

    // Next counts and phases; everything holds unless pix_en is high.
    always_comb begin
        h_d    = h_q;
        v_d    = v_q;
        h_ph_d = h_ph_q;
        v_ph_d = v_ph_q;
        h_wrap = 1'b0;
        if (vga.pix_en) begin
            if (h_q == H_LAST) begin
                h_d    = 10'd0;
                h_wrap = 1'b1;
                v_d    = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
            h_ph_d = step_phase(h_ph_q, h_d, H_FRONT_START, H_SYNC_START, H_BACK_START);
            if (h_wrap) begin
                v_ph_d = step_phase(v_ph_q, v_d, V_FRONT_START, V_SYNC_START, V_BACK_START);
            end
        end
    end

    // Counter/phase state and all registered outputs; reset parks the raster
    // on the last pixel of the last line so the first tick lands on (0,0).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_q           <= H_LAST;
            v_q           <= V_LAST;
            h_ph_q        <= PH_BACK;
            v_ph_q        <= PH_BACK;
            pix_x_q       <= 10'd0;
            pix_y_q       <= 10'd0;
            h_sync_q      <= SYNC_OFF;
            v_sync_q      <= SYNC_OFF;
            video_on_q    <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_q    <= h_d;
            v_q    <= v_d;
            h_ph_q <= h_ph_d;
            v_ph_q <= v_ph_d;
            if (vga.pix_en) begin
                pix_x_q    <= h_d;
                pix_y_q    <= v_d;
                h_sync_q   <= (h_ph_d == PH_SYNC) ? SYNC_ON : SYNC_OFF;
                v_sync_q   <= (v_ph_d == PH_SYNC) ? SYNC_ON : SYNC_OFF;
                video_on_q <= (h_ph_d == PH_VISIBLE) && (v_ph_d == PH_VISIBLE);
            end
            line_start_q  <= vga.pix_en && (h_d == 10'd0);
            frame_start_q <= vga.pix_en && (h_d == 10'd0) && (v_d == 10'd0);
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [7:0] frame_cnt_q;

    // Frame counter steps on the same edge that raises frame_start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= 8'd0;
        end else if (vga.pix_en && (h_d == 10'd0) && (v_d == 10'd0)) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
        end
    end

    assign vga.frame_cnt = frame_cnt_q;
`endif

    assign vga.pix_x       = pix_x_q;
    assign vga.pix_y       = pix_y_q;
    assign vga.h_sync      = h_sync_q;
    assign vga.v_sync      = v_sync_q;
    assign vga.video_on    = video_on_q;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;
    assign vga.dbg_h_phase = h_ph_q;
    assign vga.dbg_v_phase = v_ph_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen. A reduced raster (15 x 8) exercises frames, pix_en
// gating, async reset and (with VGA_FRAME_CNT_EN) the frame counter wrap; a
// second instance at default 640x480 timing checks two full lines.
module tb_vga_sync_gen;

    localparam int HV = 8;
    localparam int HF = 2;
    localparam int HS = 3;
    localparam int HB = 2;
    localparam int HT = HV + HF + HS + HB;   // 15
    localparam int VV = 4;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 1;
    localparam int VT = VV + VF + VS + VB;   // 8

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    logic rst_def;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    vga_sync_gen_if vif();
    vga_sync_gen_if vif_def();

    vga_sync_gen #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .vga(vif)
    );

    vga_sync_gen dut_def (
        .clk(clk),
        .rst(rst_def),
        .vga(vif_def)
    );

    // ---------------- reference model (small raster) ----------------
    int         m_h, m_v;
    logic [9:0] e_x, e_y;
    logic       e_hs, e_vs, e_vo, e_ls, e_fs;
    logic [7:0] e_fc;

    task automatic model_reset();
        m_h  = HT - 1;
        m_v  = VT - 1;
        e_x  = 10'd0;
        e_y  = 10'd0;
        e_hs = 1'b1;
        e_vs = 1'b1;
        e_vo = 1'b0;
        e_ls = 1'b0;
        e_fs = 1'b0;
        e_fc = 8'd0;
    endtask

    // Drive pix_en for one clk, then advance the model to match that edge.
    task automatic tick(input logic en);
        vif.pix_en = en;
        @(posedge clk);
        #1;
        e_ls = 1'b0;
        e_fs = 1'b0;
        if (en) begin
            if (m_h == HT - 1) begin
                m_h = 0;
                m_v = (m_v == VT - 1) ? 0 : m_v + 1;
            end else begin
                m_h = m_h + 1;
            end
            e_x  = 10'(m_h);
            e_y  = 10'(m_v);
            e_hs = !((m_h >= HV + HF) && (m_h < HV + HF + HS));
            e_vs = !((m_v >= VV + VF) && (m_v < VV + VF + VS));
            e_vo = (m_h < HV) && (m_v < VV);
            e_ls = (m_h == 0);
            e_fs = (m_h == 0) && (m_v == 0);
            if (e_fs) e_fc = e_fc + 8'd1;
        end
    endtask

    function automatic logic [24:0] obs_s();
        return {vif.pix_x, vif.pix_y, vif.h_sync, vif.v_sync,
                vif.video_on, vif.line_start, vif.frame_start};
    endfunction

    function automatic logic [24:0] exp_s();
        return {e_x, e_y, e_hs, e_vs, e_vo, e_ls, e_fs};
    endfunction

    function automatic logic [24:0] obs_d();
        return {vif_def.pix_x, vif_def.pix_y, vif_def.h_sync, vif_def.v_sync,
                vif_def.video_on, vif_def.line_start, vif_def.frame_start};
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [24:0] want;
        rst = 1'b1;
        vif.pix_en = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        want = {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        checks++;
        if (obs_s() !== want) begin
            errors++;
            $display("FAIL reset_values got=%h exp=%h", obs_s(), want);
        end
`ifdef VGA_FRAME_CNT_EN
        checks++;
        if (vif.frame_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_frame_cnt got=%0d exp=0", vif.frame_cnt);
        end
`endif
        rst = 1'b0;
        tick(1'b0);
        checks++;
        if (obs_s() !== want) begin
            errors++;
            $display("FAIL idle_after_release got=%h exp=%h", obs_s(), want);
        end
        tick(1'b1);
        want = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        checks++;
        if (obs_s() !== want) begin
            errors++;
            $display("FAIL first_tick got=%h exp=%h", obs_s(), want);
        end
`ifdef VGA_FRAME_CNT_EN
        checks++;
        if (vif.frame_cnt !== 8'd1) begin
            errors++;
            $display("FAIL first_frame_cnt got=%0d exp=1", vif.frame_cnt);
        end
`endif
        tick(1'b0);
        want = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        checks++;
        if (obs_s() !== want) begin
            errors++;
            $display("FAIL strobe_clear_hold got=%h exp=%h", obs_s(), want);
        end
    endtask

    task automatic test_full_frame();
        int ls_n = 0, fs_n = 0, vo_n = 0, hs_low = 0, vs_low = 0;
        for (int i = 0; i < 2 * HT * VT; i++) begin
            tick(1'b1);
            checks++;
            if (obs_s() !== exp_s()) begin
                errors++;
                $display("FAIL frame_cycle_%0d got=%h exp=%h", i, obs_s(), exp_s());
            end
            ls_n   += int'(vif.line_start);
            fs_n   += int'(vif.frame_start);
            vo_n   += int'(vif.video_on);
            hs_low += int'(!vif.h_sync);
            vs_low += int'(!vif.v_sync);
        end
        checks++;
        if (ls_n != 2 * VT) begin
            errors++;
            $display("FAIL line_start_count got=%0d exp=%0d", ls_n, 2 * VT);
        end
        checks++;
        if (fs_n != 2) begin
            errors++;
            $display("FAIL frame_start_count got=%0d exp=2", fs_n);
        end
        checks++;
        if (vo_n != 2 * HV * VV) begin
            errors++;
            $display("FAIL video_on_count got=%0d exp=%0d", vo_n, 2 * HV * VV);
        end
        checks++;
        if (hs_low != 2 * VT * HS) begin
            errors++;
            $display("FAIL h_sync_low_count got=%0d exp=%0d", hs_low, 2 * VT * HS);
        end
        checks++;
        if (vs_low != 2 * VS * HT) begin
            errors++;
            $display("FAIL v_sync_low_count got=%0d exp=%0d", vs_low, 2 * VS * HT);
        end
    endtask

    task automatic test_pix_en_toggle();
        int strobe_cycles = 0;
        for (int i = 0; i < 4 * HT; i++) begin
            tick((i % 2) == 0);
            checks++;
            if (obs_s() !== exp_s()) begin
                errors++;
                $display("FAIL toggle_cycle_%0d got=%h exp=%h", i, obs_s(), exp_s());
            end
            strobe_cycles += int'(vif.line_start);
        end
        // 30 ticks from pix_x=0 cross exactly two line starts
        checks++;
        if (strobe_cycles != 2) begin
            errors++;
            $display("FAIL toggle_strobe_width got=%0d exp=2", strobe_cycles);
        end
    endtask

    task automatic test_reset_mid_sync();
        logic [24:0] want;
        int budget = 2 * HT * VT;
        while (m_h != HV + HF + 1 && budget > 0) begin
            tick(1'b1);
            budget--;
        end
        checks++;
        if (budget == 0) begin
            errors++;
            $display("FAIL reach_hsync got=timeout exp=h%0d", HV + HF + 1);
        end
        checks++;
        if (vif.h_sync !== 1'b0) begin
            errors++;
            $display("FAIL in_hsync got=%b exp=0", vif.h_sync);
        end
        #3;
        rst = 1'b1;
        #1;
        want = {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        checks++;
        if (obs_s() !== want) begin
            errors++;
            $display("FAIL async_reset got=%h exp=%h", obs_s(), want);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(1'b1);
        want = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        checks++;
        if (obs_s() !== want) begin
            errors++;
            $display("FAIL restart_tick got=%h exp=%h", obs_s(), want);
        end
    endtask

`ifdef VGA_FRAME_CNT_EN
    task automatic test_frame_cnt();
        int seen_zero = 0;
        for (int i = 0; i < 256 * HT * VT; i++) begin
            tick(1'b1);
            if (e_fs || vif.frame_start) begin
                checks++;
                if (vif.frame_cnt !== e_fc || vif.frame_start !== e_fs) begin
                    errors++;
                    $display("FAIL frame_cnt_step got=%0d/%b exp=%0d/%b",
                             vif.frame_cnt, vif.frame_start, e_fc, e_fs);
                end
                if (e_fc == 8'd0) seen_zero++;
            end
        end
        checks++;
        if (vif.frame_cnt !== 8'd1 || seen_zero != 1) begin
            errors++;
            $display("FAIL frame_cnt_wrap got=%0d zeros=%0d exp=1 zeros=1",
                     vif.frame_cnt, seen_zero);
        end
    endtask
`endif

    task automatic test_default_line();
        logic [24:0] want;
        int x, y, hs_low = 0, ls_n = 0;
        rst_def = 1'b1;
        vif_def.pix_en = 1'b0;
        @(posedge clk);
        #1;
        want = {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        checks++;
        if (obs_d() !== want) begin
            errors++;
            $display("FAIL def_reset got=%h exp=%h", obs_d(), want);
        end
        rst_def = 1'b0;
        for (int i = 0; i <= 1600; i++) begin
            vif_def.pix_en = 1'b1;
            @(posedge clk);
            #1;
            x = i % 800;
            y = i / 800;
            want = {10'(x), 10'(y), !((x >= 656) && (x <= 751)), 1'b1,
                    (x < 640), (x == 0), (i == 0)};
            checks++;
            if (obs_d() !== want) begin
                errors++;
                $display("FAIL def_cycle_%0d got=%h exp=%h", i, obs_d(), want);
            end
            hs_low += int'(!vif_def.h_sync);
            ls_n   += int'(vif_def.line_start);
        end
        checks++;
        if (hs_low != 192 || ls_n != 3) begin
            errors++;
            $display("FAIL def_line_counts got=%0d/%0d exp=192/3", hs_low, ls_n);
        end
        vif_def.pix_en = 1'b0;
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        rst = 1'b1;
        rst_def = 1'b1;
        vif.pix_en = 1'b0;
        vif_def.pix_en = 1'b0;
        test_reset();
        test_full_frame();
        test_pix_en_toggle();
        test_reset_mid_sync();
`ifdef VGA_FRAME_CNT_EN
        test_frame_cnt();
`endif
        test_default_line();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
